// File: rtl/mmio_host_pkg.sv
// Shared register offsets and STATUS bit positions for the MMIO host/debug port.
package mmio_host_pkg;

    localparam logic [5:0] CH0    = 6'h00;
    localparam logic [5:0] TXPUSH = 6'h20;
    localparam logic [5:0] STATUS = 6'h24;
    localparam logic [5:0] LEDSEL = 6'h28;
    localparam logic [5:0] HALT   = 6'h2C;
    localparam logic [5:0] CYCLE  = 6'h30;

    localparam int unsigned ST_EMPTY = 0;
    localparam int unsigned ST_FULL  = 1;
    localparam int unsigned ST_HALT  = 2;
    localparam int unsigned ST_OVF   = 3;
    localparam int unsigned ST_COUNT = 8;

    function automatic logic [7:0] sat8(input logic [31:0] v);
        return (v > 32'd255) ? 8'hFF : v[7:0];
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO; a push while full is accepted only if a pop frees a slot in the same cycle.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_data,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_data,
    output logic                       o_full,
    output logic                       o_empty,
    output logic                       o_drop,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push, do_pop;

    assign o_full  = (count_q == CW'(DEPTH));
    assign o_empty = (count_q == '0);
    assign do_pop  = i_pop && !o_empty;
    assign do_push = i_push && (!o_full || do_pop);
    assign o_drop  = i_push && !do_push;
    assign o_data  = mem_q[rd_ptr_q];
    assign o_count = count_q;

    always_ff @(posedge i_clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= i_data;
        end
    end

    // DEPTH is a power of two, so pointers wrap naturally
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/mmio_host_port.sv
// MMIO host/debug port: output channels, LED view, console TX FIFO, halt and status.
// Define MMIO_HOST_CYCLE_CNT_EN to build the free-running cycle counter at offset 0x30.
module mmio_host_port
    import mmio_host_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h8000_1000,
    parameter int unsigned NUM_CH     = 4,
    parameter int unsigned LED_W      = 16,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_cs,
    input  logic                  i_wr_en,
    input  logic [3:0]            i_b_en,
    input  logic [31:0]           i_wr_data,
    input  logic [31:0]           i_addr,
    output logic                  o_ack,
    output logic [31:0]           o_rd_data,
    output logic [7:0]            o_tx_data,
    output logic                  o_tx_valid,
    input  logic                  i_tx_ready,
    output logic [LED_W-1:0]      o_led,
    output logic [NUM_CH*32-1:0]  o_ch,
    output logic                  o_halt
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

    logic [31:0] ch_q [NUM_CH];
    logic [31:0] ch_d [NUM_CH];
    logic [2:0]  led_sel_q;
    logic        halt_q, ovf_q, ack_q;
    logic [31:0] rd_data_q, rd_val, status, cyc_val;
    logic        hit, accept, wr_acc, push, drop, full, empty, ovf_clr;
    logic [5:0]  off;
    logic [CW-1:0] count;
    logic        unused;

    assign hit    = i_cs && (i_addr[31:6] == BASE_ADDR[31:6]);
    assign accept = hit && !ack_q;
    assign wr_acc = accept && i_wr_en;
    assign off    = {i_addr[5:2], 2'b00};
    assign unused = ^i_addr[1:0];

    assign push    = wr_acc && (off == TXPUSH) && i_b_en[0];
    assign ovf_clr = wr_acc && (off == STATUS) && i_b_en[0] && i_wr_data[ST_OVF];

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (push),
        .i_data  (i_wr_data[7:0]),
        .i_pop   (i_tx_ready),
        .o_data  (o_tx_data),
        .o_full  (full),
        .o_empty (empty),
        .o_drop  (drop),
        .o_count (count)
    );

    assign o_tx_valid = !empty;

`ifdef MMIO_HOST_CYCLE_CNT_EN
    logic [31:0] cyc_q;
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            cyc_q <= '0;
        end else if (wr_acc && (off == CYCLE)) begin
            cyc_q <= '0;
        end else begin
            cyc_q <= cyc_q + 32'd1;
        end
    end
    assign cyc_val = cyc_q;
`else
    assign cyc_val = '0;
`endif

    always_comb begin
        status = '0;
        status[ST_EMPTY] = empty;
        status[ST_FULL]  = full;
        status[ST_HALT]  = halt_q;
        status[ST_OVF]   = ovf_q;
        status[ST_COUNT +: 8] = sat8(32'(count));
    end

    always_comb begin
        rd_val = '0;
        if (!off[5]) begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (off[4:2] == 3'(k)) rd_val = ch_q[k];
            end
        end else begin
            case (off)
                STATUS:  rd_val = status;
                LEDSEL:  rd_val = {29'b0, led_sel_q};
                HALT:    rd_val = {31'b0, halt_q};
                CYCLE:   rd_val = cyc_val;
                default: rd_val = '0;
            endcase
        end
    end

    always_comb begin
        for (int k = 0; k < NUM_CH; k++) begin
            ch_d[k] = ch_q[k];
            if (wr_acc && !off[5] && (off[4:2] == 3'(k))) begin
                for (int j = 0; j < 4; j++) begin
                    if (i_b_en[j]) ch_d[k][8*j +: 8] = i_wr_data[8*j +: 8];
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            for (int k = 0; k < NUM_CH; k++) ch_q[k] <= '0;
            led_sel_q <= '0;
            halt_q    <= 1'b0;
            ovf_q     <= 1'b0;
            ack_q     <= 1'b0;
            rd_data_q <= '0;
        end else begin
            for (int k = 0; k < NUM_CH; k++) ch_q[k] <= ch_d[k];
            ack_q     <= accept;
            rd_data_q <= (accept && !i_wr_en) ? rd_val : '0;
            if (wr_acc && (off == LEDSEL) && i_b_en[0]) led_sel_q <= i_wr_data[2:0];
            if (wr_acc && (off == HALT) && i_b_en[0] && i_wr_data[0]) halt_q <= 1'b1;
            // a dropped push in the same cycle as a clear leaves overflow set
            if (drop)         ovf_q <= 1'b1;
            else if (ovf_clr) ovf_q <= 1'b0;
        end
    end

    always_comb begin
        o_led = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (led_sel_q == 3'(k)) o_led = ch_q[k][LED_W-1:0];
        end
    end

    always_comb begin
        for (int k = 0; k < NUM_CH; k++) o_ch[32*k +: 32] = ch_q[k];
    end

    assign o_ack     = ack_q;
    assign o_rd_data = rd_data_q;
    assign o_halt    = halt_q;

endmodule
